// File: rtl/turn_controller_pkg.sv
// Shared types and helpers for the paper-soccer turn sequencer.
// Holds direction/state encodings, colour constants, step lookups
// and the goal-mouth predicate used by the legality checker.
package turn_controller_pkg;

  localparam logic COLOR_BLUE = 1'b0;
  localparam logic COLOR_RED  = 1'b1;

  typedef enum logic [2:0] {
    DIR_A = 3'd0, DIR_B = 3'd1, DIR_C = 3'd2, DIR_D = 3'd3,
    DIR_E = 3'd4, DIR_F = 3'd5, DIR_G = 3'd6, DIR_H = 3'd7
  } dir_e;

  typedef enum logic [2:0] {
    S_IDLE, S_ASK, S_WAIT, S_RD, S_RD2, S_WR, S_CHK, S_OVER
  } state_e;

  // Horizontal step of a direction: b/c/d go right, f/g/h go left.
  function automatic logic signed [8:0] dir_dx(input dir_e d);
    case (d)
      DIR_B, DIR_C, DIR_D: dir_dx = 9'sd1;
      DIR_F, DIR_G, DIR_H: dir_dx = -9'sd1;
      default:             dir_dx = 9'sd0;
    endcase
  endfunction

  // Vertical step of a direction: h/a/b go up, d/e/f go down.
  function automatic logic signed [8:0] dir_dy(input dir_e d);
    case (d)
      DIR_H, DIR_A, DIR_B: dir_dy = 9'sd1;
      DIR_D, DIR_E, DIR_F: dir_dy = -9'sd1;
      default:             dir_dy = 9'sd0;
    endcase
  endfunction

  // True when x is one of the three goal-mouth columns w/2-1, w/2, w/2+1.
  function automatic logic in_goal(input logic [7:0] x, input logic [7:0] w);
    logic [8:0] half;
    logic [8:0] xe;
    half = {1'b0, w} >> 1;
    xe   = {1'b0, x};
    in_goal = (xe + 9'd1 == half) || (xe == half) || (xe == half + 9'd1);
  endfunction

endpackage

// File: rtl/turn_controller_if.sv
// Board-memory access port between the sequencer and the memory arbiter.
// Address/direction/we are held stable by the master while req is high;
// read data returns the cycle after a granted read.
interface turn_controller_if;
  logic       mem_req;
  logic       mem_gnt;
  logic       mem_we;
  logic [7:0] mem_x;
  logic [7:0] mem_y;
  logic [2:0] mem_dir;
  logic       mem_edge_used;
  logic       mem_node_visited;

  modport master (
    output mem_req, mem_we, mem_x, mem_y, mem_dir,
    input  mem_gnt, mem_edge_used, mem_node_visited
  );

  modport slave (
    input  mem_req, mem_we, mem_x, mem_y, mem_dir,
    output mem_gnt, mem_edge_used, mem_node_visited
  );
endinterface

// File: rtl/turn_controller_move_legality.sv
// Geometric move check: target node, bounds, border walk, border and goal hits.
// Purely combinational, zero latency.
// No handshake; the caller holds inputs stable while it samples the outputs.
module move_legality
  import turn_controller_pkg::*;
(
  input  logic [7:0] x,
  input  logic [7:0] y,
  input  logic [7:0] width,
  input  logic [7:0] length,
  input  dir_e       dir,
  output logic [7:0] nx,
  output logic [7:0] ny,
  output logic       geo_ok,
  output logic       on_border,
  output logic       goal,
  output logic       goal_color
);

  logic signed [8:0] sx;
  logic signed [8:0] sy;
  logic              in_bounds;
  logic              border_walk;

  // Target node and all edge-independent legality/outcome flags.
  always_comb begin
    sx = $signed({1'b0, x}) + dir_dx(dir);
    sy = $signed({1'b0, y}) + dir_dy(dir);
    in_bounds = (sx >= 9'sd0) && (sx <= $signed({1'b0, width})) &&
                (sy >= 9'sd0) && (sy <= $signed({1'b0, length}));
    border_walk = (((dir == DIR_C) || (dir == DIR_G)) && ((y == 8'd0) || (y == length))) ||
                  (((dir == DIR_A) || (dir == DIR_E)) && ((x == 8'd0) || (x == width)));
    geo_ok     = in_bounds && !border_walk;
    nx         = sx[7:0];
    ny         = sy[7:0];
    on_border  = (nx == 8'd0) || (nx == width) || (ny == 8'd0) || (ny == length);
    goal       = in_bounds && ((ny == length) || (ny == 8'd0)) && in_goal(nx, width);
    goal_color = (ny == length) ? COLOR_BLUE : COLOR_RED;
  end

endmodule

// File: rtl/turn_controller.sv
// Paper-soccer sequencer: collects a move, validates it against board memory, commits it.
// Human strobe to ball update is 4 cycles with immediate grants.
// Stalls in RD/WR while mem_gnt is low; moves from the inactive source are dropped.
module turn_controller
  import turn_controller_pkg::*;
#(
  parameter logic AI_COLOR    = COLOR_BLUE,
  parameter logic FIRST_COLOR = COLOR_RED
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_game,
  input  logic [7:0] width_in,
  input  logic [7:0] length_in,
  input  logic [2:0] human_dir,
  input  logic       human_dir_valid,
  output logic       ai_my_turn,
  output logic [7:0] ai_x,
  output logic [7:0] ai_y,
  output logic [7:0] ai_width,
  output logic [7:0] ai_length,
  output logic       ai_color,
  input  logic       ai_idle,
  input  logic [2:0] ai_direction,
  input  logic       ai_direction_valid,
  turn_controller_if.master mem,
  output logic [7:0] ball_x,
  output logic [7:0] ball_y,
  output logic       turn_color,
  output logic       move_reject,
  output logic       game_over,
  output logic       winner
);

  state_e     state, nstate;
  logic [7:0] width, length;
  logic       turn;
  dir_e       dir_q;
  logic       visited_q, goal_q, goal_color_q, bounce_q;

  logic       load_game, cap_dir, latch_vis, commit, toggle, end_game, win_val;
  logic [7:0] nx, ny;
  logic       geo_ok, on_border, goal, goal_color;

  wire  ai_turn = (turn == AI_COLOR);
  wire  act_vld = ai_turn ? ai_direction_valid : human_dir_valid;
  wire  dir_e act_dir = dir_e'(ai_turn ? ai_direction : human_dir);

  move_legality u_legal (
    .x(ball_x), .y(ball_y), .width(width), .length(length), .dir(dir_q),
    .nx(nx), .ny(ny), .geo_ok(geo_ok), .on_border(on_border),
    .goal(goal), .goal_color(goal_color)
  );

  // State register; reset aborts any game and drops mem_req immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= nstate;
  end

  // Next-state and per-state control strobes.
  always_comb begin
    nstate      = state;
    ai_my_turn  = 1'b0;
    move_reject = 1'b0;
    load_game   = 1'b0;
    cap_dir     = 1'b0;
    latch_vis   = 1'b0;
    commit      = 1'b0;
    toggle      = 1'b0;
    end_game    = 1'b0;
    win_val     = COLOR_BLUE;
    case (state)
      S_IDLE, S_OVER: if (start_game) begin
        load_game = 1'b1;
        nstate    = S_ASK;
      end
      S_ASK: if (!ai_turn || ai_idle) begin
        ai_my_turn = ai_turn;
        if (act_vld) begin
          cap_dir = 1'b1;
          nstate  = S_RD;
        end else begin
          nstate  = S_WAIT;
        end
      end
      S_WAIT: if (act_vld) begin
        cap_dir = 1'b1;
        nstate  = S_RD;
      end
      S_RD: if (mem.mem_gnt) nstate = S_RD2;
      S_RD2: begin
        latch_vis = 1'b1;
        if (geo_ok && !mem.mem_edge_used) begin
          nstate = S_WR;
        end else if (ai_turn) begin
          // An AI with no legal move still reports something; that forfeits.
          end_game = 1'b1;
          win_val  = ~AI_COLOR;
          nstate   = S_OVER;
        end else begin
          move_reject = 1'b1;
          nstate      = S_WAIT;
        end
      end
      S_WR: if (mem.mem_gnt) begin
        commit = 1'b1;
        nstate = S_CHK;
      end
      S_CHK: if (goal_q) begin
        end_game = 1'b1;
        win_val  = goal_color_q;
        nstate   = S_OVER;
      end else begin
        toggle = !bounce_q;
        nstate = S_ASK;
      end
      default: nstate = S_IDLE;
    endcase
  end

  // Game context, ball, turn and move bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      width        <= 8'd0;
      length       <= 8'd0;
      ball_x       <= 8'd0;
      ball_y       <= 8'd0;
      turn         <= 1'b0;
      winner       <= 1'b0;
      dir_q        <= DIR_A;
      visited_q    <= 1'b0;
      goal_q       <= 1'b0;
      goal_color_q <= 1'b0;
      bounce_q     <= 1'b0;
    end else begin
      if (load_game) begin
        width  <= width_in;
        length <= length_in;
        ball_x <= width_in >> 1;
        ball_y <= length_in >> 1;
        turn   <= FIRST_COLOR;
        winner <= 1'b0;
      end
      if (cap_dir)   dir_q     <= act_dir;
      if (latch_vis) visited_q <= mem.mem_node_visited;
      if (commit) begin
        // Outcome flags come from the pre-move ball, so capture them with the move.
        ball_x       <= nx;
        ball_y       <= ny;
        goal_q       <= goal;
        goal_color_q <= goal_color;
        bounce_q     <= visited_q | on_border;
      end
      if (toggle)   turn   <= ~turn;
      if (end_game) winner <= win_val;
    end
  end

  assign mem.mem_req = (state == S_RD) || (state == S_WR);
  assign mem.mem_we  = (state == S_WR);
  assign mem.mem_x   = ball_x;
  assign mem.mem_y   = ball_y;
  assign mem.mem_dir = dir_q;

  assign ai_x       = ball_x;
  assign ai_y       = ball_y;
  assign ai_width   = width;
  assign ai_length  = length;
  assign ai_color   = AI_COLOR;
  assign turn_color = turn;
  assign game_over  = (state == S_OVER);

endmodule

// File: tb/tb_turn_controller.sv
// Directed bench for turn_controller: w=8, l=10, human red moves first, AI blue.
// Walks the ball through legal, bounce, reject, forfeit and goal cases,
// then checks asynchronous reset during a stalled write.
module tb_turn_controller;
  import turn_controller_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_game = 1'b0;
  logic [7:0] width_in = 8'd8;
  logic [7:0] length_in = 8'd10;
  logic [2:0] human_dir = 3'd0;
  logic       human_dir_valid = 1'b0;
  logic       ai_idle = 1'b1;
  logic [2:0] ai_direction = 3'd0;
  logic       ai_direction_valid = 1'b0;
  logic       ai_my_turn, ai_color, turn_color, move_reject, game_over, winner;
  logic [7:0] ai_x, ai_y, ai_width, ai_length, ball_x, ball_y;

  logic gnt_rd_en = 1'b1, gnt_wr_en = 1'b1, edge_used_r = 1'b0, visited_r = 1'b0;
  int   vectors = 0, miscompares = 0, wr_cnt = 0, rej_cnt = 0, cyc = 0, w0 = 0;
  logic [18:0] last_rd = '0;

  turn_controller_if m();
  assign m.mem_gnt          = m.mem_req & (m.mem_we ? gnt_wr_en : gnt_rd_en);
  assign m.mem_edge_used    = edge_used_r;
  assign m.mem_node_visited = visited_r;

  turn_controller dut (
    .clk(clk), .rst(rst), .start_game(start_game),
    .width_in(width_in), .length_in(length_in),
    .human_dir(human_dir), .human_dir_valid(human_dir_valid),
    .ai_my_turn(ai_my_turn), .ai_x(ai_x), .ai_y(ai_y),
    .ai_width(ai_width), .ai_length(ai_length), .ai_color(ai_color),
    .ai_idle(ai_idle), .ai_direction(ai_direction), .ai_direction_valid(ai_direction_valid),
    .mem(m),
    .ball_x(ball_x), .ball_y(ball_y), .turn_color(turn_color),
    .move_reject(move_reject), .game_over(game_over), .winner(winner)
  );

  always #5 clk = ~clk;

  // Memory-side observer: granted writes, last granted read, reject pulses.
  always @(posedge clk) begin
    if (!rst) begin
      if (m.mem_req && m.mem_gnt) begin
        if (m.mem_we) wr_cnt++;
        else          last_rd = {m.mem_x, m.mem_y, m.mem_dir};
      end
      if (move_reject) rej_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one move from the AI or the human and wait for the sequencer to settle.
  task automatic move(input bit ai, input logic [2:0] d, output int ncyc);
    int n;
    bit ok;
    n  = 0;
    ok = 1'b0;
    while (n < 40 && !ok) begin
      ok = ai ? ai_my_turn : (dut.state == S_WAIT);
      if (!ok) begin tick(); n++; end
    end
    if (ai) chk("ai_ready", {31'b0, ok}, 32'd1);
    else    chk("human_ready", {31'b0, ok}, 32'd1);
    if (ai) begin ai_direction = d; ai_direction_valid = 1'b1; end
    else    begin human_dir = d; human_dir_valid = 1'b1; end
    tick();
    ai_direction_valid = 1'b0;
    human_dir_valid    = 1'b0;
    n  = 1;
    ok = 1'b0;
    while (n < 40 && !ok) begin
      ok = (dut.state == S_ASK) || (dut.state == S_WAIT) || (dut.state == S_OVER);
      if (!ok) begin tick(); n++; end
    end
    chk("move_done", {31'b0, ok}, 32'd1);
    ncyc = n;
  endtask

  task automatic start();
    start_game = 1'b1;
    tick();
    start_game = 1'b0;
  endtask

  initial begin
    #1;
    chk("rst_ball", {ball_x, ball_y}, 32'd0);
    chk("rst_flags", {ai_color, turn_color, game_over, winner, move_reject, ai_my_turn, m.mem_req, m.mem_we}, 32'd0);
    repeat (2) tick();
    rst = 1'b0;
    tick();
    start();
    chk("start_ball", {ball_x, ball_y}, {8'd4, 8'd5});
    chk("start_turn", {31'b0, turn_color}, 32'd1);
    chk("start_ctx", {ai_width, ai_length}, {8'd8, 8'd10});

    // Human a from (4,5): read (4,5,a), one write, ball (4,6), AI asked.
    move(1'b0, 3'd0, cyc);
    chk("m1_latency", cyc, 32'd5);
    chk("m1_read", {13'b0, last_rd}, {13'b0, 8'd4, 8'd5, 3'd0});
    chk("m1_writes", wr_cnt, 32'd1);
    chk("m1_ball", {ball_x, ball_y}, {8'd4, 8'd6});
    chk("m1_ai_pulse", {ai_my_turn, turn_color, ai_x, ai_y}, {1'b1, 1'b0, 8'd4, 8'd6});

    move(1'b1, 3'd2, cyc);   // AI c -> (5,6)
    move(1'b0, 3'd2, cyc);   // human c -> (6,6)
    move(1'b1, 3'd2, cyc);   // AI c -> (7,6)
    move(1'b0, 3'd2, cyc);   // human c -> (8,6) on border: bounce
    chk("border_bounce", {turn_color, ball_x, ball_y}, {1'b1, 8'd8, 8'd6});
    move(1'b0, 3'd5, cyc);   // human f -> (7,5)
    move(1'b1, 3'd3, cyc);   // AI d -> (8,4) bounce
    chk("ai_bounce", {turn_color, ball_x, ball_y}, {1'b0, 8'd8, 8'd4});
    move(1'b1, 3'd5, cyc);   // AI f -> (7,3)
    move(1'b0, 3'd2, cyc);   // human c -> (8,3) bounce
    chk("at_8_3", {turn_color, ball_x, ball_y}, {1'b1, 8'd8, 8'd3});

    // Human c off the right edge: rejected, nothing written, still red.
    w0 = wr_cnt;
    move(1'b0, 3'd2, cyc);
    chk("rej_pulse", rej_cnt, 32'd1);
    chk("rej_no_write", wr_cnt, w0);
    chk("rej_state", {turn_color, ball_x, ball_y}, {1'b1, 8'd8, 8'd3});

    // Visited target: move commits, same colour keeps the turn.
    visited_r = 1'b1;
    move(1'b0, 3'd6, cyc);   // human g -> (7,3)
    visited_r = 1'b0;
    chk("visit_bounce", {turn_color, ball_x, ball_y}, {1'b1, 8'd7, 8'd3});
    move(1'b0, 3'd0, cyc);   // human a -> (7,4)
    chk("toggle_to_ai", {31'b0, turn_color}, 32'd0);

    // AI picks a used edge: forfeits to red.
    w0 = wr_cnt;
    edge_used_r = 1'b1;
    move(1'b1, 3'd0, cyc);
    edge_used_r = 1'b0;
    chk("ai_forfeit", {game_over, winner, ball_x, ball_y}, {1'b1, 1'b1, 8'd7, 8'd4});
    chk("forfeit_no_write", wr_cnt, w0);

    // Second game; a start pulse mid-game must be ignored.
    start();
    chk("restart", {game_over, winner, turn_color, ball_x, ball_y}, {3'b001, 8'd4, 8'd5});
    width_in   = 8'd12;
    start_game = 1'b1;
    tick();
    start_game = 1'b0;
    width_in   = 8'd8;
    chk("start_ignored", {ai_width, ball_x, ball_y}, {8'd8, 8'd4, 8'd5});
    move(1'b0, 3'd0, cyc);   // human a -> (4,6)
    move(1'b1, 3'd7, cyc);   // AI h -> (3,7)
    visited_r = 1'b1;
    move(1'b0, 3'd0, cyc);   // human a -> (3,8) bounce
    visited_r = 1'b0;
    move(1'b0, 3'd0, cyc);   // human a -> (3,9)
    chk("pre_goal", {turn_color, ai_x, ai_y}, {1'b0, 8'd3, 8'd9});
    move(1'b1, 3'd1, cyc);   // AI b -> (4,10): blue goal
    chk("blue_goal", {game_over, winner, ball_x, ball_y}, {1'b1, 1'b0, 8'd4, 8'd10});
    tick();
    chk("over_hold", {game_over, ball_x, ball_y}, {1'b1, 8'd4, 8'd10});

    // Third game: write grant withheld, then reset with no clock edge.
    start();
    gnt_wr_en = 1'b0;
    w0 = wr_cnt;
    tick();
    human_dir = 3'd0;
    human_dir_valid = 1'b1;
    tick();
    human_dir_valid = 1'b0;
    repeat (22) tick();
    chk("wr_stall", {m.mem_req, m.mem_we, m.mem_x, m.mem_y, m.mem_dir}, {2'b11, 8'd4, 8'd5, 3'd0});
    chk("wr_stall_ball", {ball_x, ball_y}, {8'd4, 8'd5});
    #2;
    rst = 1'b1;
    #1;
    chk("arst_mem", {m.mem_req, m.mem_we, m.mem_x, m.mem_y, m.mem_dir}, 32'd0);
    chk("arst_ball", {ball_x, ball_y, ai_width, ai_length}, 32'd0);
    chk("arst_flags", {ai_color, turn_color, game_over, winner, move_reject, ai_my_turn, ai_x[0], ai_y[0]}, 32'd0);
    chk("arst_no_write", wr_cnt, w0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
